// File: rtl/blocky_pkg.sv
// Shared types and constants for the high-score tracker: FSM states and BCD digit type.
package blocky_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, CMP, COMMIT} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/high_score_tracker_if.sv
// Game-control and score-display signals between the game logic (master) and the tracker (slave).
interface high_score_tracker_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    game_start;
  logic                    game_over;
  logic                    score_inc;
  logic [4*NUM_DIGITS-1:0] score_bcd;
  logic [4*NUM_DIGITS-1:0] high_score_bcd;
  logic                    new_record;
  logic                    busy;

  modport master (
    output game_start, game_over, score_inc,
    input  score_bcd, high_score_bcd, new_record, busy
  );

  modport slave (
    input  game_start, game_over, score_inc,
    output score_bcd, high_score_bcd, new_record, busy
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One decade of the BCD score counter; instances ripple through carry_out into the next digit.
module bcd_digit_counter
  import blocky_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc_in,
  output bcd_digit_t digit,
  output logic       carry_out
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc_in) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign carry_out = inc_in && (digit_q == BCD_MAX);

endmodule

// File: rtl/high_score_tracker.sv
// Counts the game score in BCD and keeps the session high score, compared MSD-first one digit per cycle.
// Build option: define SCORE_SATURATE_EN to hold the score at all-9s instead of wrapping to zero.
module high_score_tracker
  import blocky_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  high_score_tracker_if.slave        bus_if
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(NUM_DIGITS - 1);

  state_t                            state_q;
  logic [IDX_W-1:0]                  idx_q;
  bcd_digit_t [NUM_DIGITS-1:0]       score_q;
  bcd_digit_t [NUM_DIGITS-1:0]       hs_q;
  logic                              new_record_q;
  logic                              busy_q;

  logic                              clr_score;
  logic                              inc_req;
  logic                              inc_chain;
  logic                              all9;
  logic [NUM_DIGITS:0]               carry;

  // Only PLAY touches the score; game_over outranks a simultaneous restart.
  always_comb begin
    clr_score = 1'b0;
    inc_req   = 1'b0;
    case (state_q)
      IDLE: clr_score = bus_if.game_start;
      PLAY: begin
        clr_score = bus_if.game_start && !bus_if.game_over;
        inc_req   = bus_if.score_inc && (bus_if.game_over || !bus_if.game_start);
      end
      default: ;
    endcase
  end

  assign all9 = (score_q == {NUM_DIGITS{BCD_MAX}});

`ifdef SCORE_SATURATE_EN
  assign inc_chain = inc_req && !all9;
`else
  assign inc_chain = inc_req;
`endif

  assign carry[0] = inc_chain;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_score),
      .inc_in    (carry[g]),
      .digit     (score_q[g]),
      .carry_out (carry[g+1])
    );
  end

  // A carry out of the top digit only ever means the score wrapped to zero.
`ifdef SCORE_SATURATE_EN
  a_no_msd_carry: assert property (@(posedge clk) disable iff (rst) !carry[NUM_DIGITS]);
`else
  a_wrap_to_zero: assert property (@(posedge clk) disable iff (rst)
                                   carry[NUM_DIGITS] |=> (score_q == '0));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= IDX_MSD;
      hs_q         <= '0;
      new_record_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      new_record_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_if.game_start) begin
            state_q <= PLAY;
          end
        end
        PLAY: begin
          if (bus_if.game_over) begin
            state_q <= CMP;
            idx_q   <= IDX_MSD;
            busy_q  <= 1'b1;
          end
        end
        CMP: begin
          if (score_q[idx_q] > hs_q[idx_q]) begin
            state_q <= COMMIT;
          end else if ((score_q[idx_q] < hs_q[idx_q]) || (idx_q == '0)) begin
            state_q <= IDLE;
            idx_q   <= IDX_MSD;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        COMMIT: begin
          hs_q         <= score_q;
          new_record_q <= 1'b1;
          state_q      <= IDLE;
          idx_q        <= IDX_MSD;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.score_bcd      = score_q;
  assign bus_if.high_score_bcd = hs_q;
  assign bus_if.new_record     = new_record_q;
  assign bus_if.busy           = busy_q;

endmodule

// File: tb/tb_high_score_tracker.sv
// Randomized and directed bench for high_score_tracker against an integer-level game/score model.
module tb_high_score_tracker;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  high_score_tracker_if #(.NUM_DIGITS(ND)) bif ();

  high_score_tracker #(.NUM_DIGITS(ND)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: score and high score as plain integers.
  int m_score = 0;
  int m_hs    = 0;
  int m_busy_left = 0;
  bit m_play    = 1'b0;
  bit m_pending = 1'b0;
  bit m_nr      = 1'b0;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d;
    r = '0;
    d = 1;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  function automatic int dig(input int v, input int i);
    return (v / (10 ** i)) % 10;
  endfunction

  function automatic int incr(input int v);
    if (v == 9999) begin
`ifdef SCORE_SATURATE_EN
      return 9999;
`else
      return 0;
`endif
    end
    return v + 1;
  endfunction

  task automatic model_step(input bit gs, input bit go, input bit si, input bit r);
    int k;
    m_nr = 1'b0;
    if (r) begin
      m_score = 0; m_hs = 0; m_busy_left = 0;
      m_play = 1'b0; m_pending = 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0 && m_pending) begin
        m_hs = m_score;
        m_nr = 1'b1;
        m_pending = 1'b0;
      end
    end else if (m_play) begin
      if (go) begin
        if (si) m_score = incr(m_score);
        k = 0;
        for (int i = ND - 1; i >= 0; i--) begin
          k++;
          if (dig(m_score, i) != dig(m_hs, i)) break;
        end
        m_pending = (m_score > m_hs);
        m_busy_left = m_pending ? k + 1 : k;
        m_play = 1'b0;
      end else if (gs) begin
        m_score = 0;
      end else if (si) begin
        m_score = incr(m_score);
      end
    end else if (gs) begin
      m_score = 0;
      m_play = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("score", bif.score_bcd, to_bcd(m_score));
    chk("high", bif.high_score_bcd, to_bcd(m_hs));
    chk("new_record", {15'b0, bif.new_record}, {15'b0, m_nr});
    chk("busy", {15'b0, bif.busy}, {15'b0, (m_busy_left > 0)});
  endtask

  // One clock: drive on the falling edge, model on the rising edge, check on the next falling edge.
  task automatic cyc(input bit gs, input bit go, input bit si, input bit r);
    bif.game_start = gs;
    bif.game_over  = go;
    bif.score_inc  = si;
    rst            = r;
    @(posedge clk);
    model_step(gs, go, si, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic play_game(input int incs);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < incs; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  int busy_cnt;

  initial begin
    bif.game_start = 1'b0;
    bif.game_over  = 1'b0;
    bif.score_inc  = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_high", bif.high_score_bcd, 16'h0000);
    chk("reset_busy", {15'b0, bif.busy}, 16'h0000);

    // First record: 12 points over an empty high score.
    play_game(12);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      busy_cnt += int'(bif.busy);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("t1_high", bif.high_score_bcd, 16'h0012);
    chk("t1_busy_len", 16'(busy_cnt), 16'd4);

    // Lower score, then a tie: neither updates.
    play_game(11);
    idle(6);
    chk("t2_high", bif.high_score_bcd, 16'h0012);
    play_game(12);
    idle(6);
    chk("t3_high", bif.high_score_bcd, 16'h0012);

    // Increment and game_over together: the incremented score is compared.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("t5_high", bif.high_score_bcd, 16'h0013);

    // Inputs during busy are ignored, and reset aborts a compare.
    play_game(20);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t6_busy_hold", bif.score_bcd, 16'h0020);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_score", bif.score_bcd, 16'h0000);
    chk("t6_rst_high", bif.high_score_bcd, 16'h0000);
    chk("t6_rst_busy", {15'b0, bif.busy}, 16'h0000);

    // Long game: decade carries and the all-9s boundary.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 999; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_0999", bif.score_bcd, 16'h0999);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_1000", bif.score_bcd, 16'h1000);
    for (int i = 0; i < 8999; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_9999", bif.score_bcd, 16'h9999);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SCORE_SATURATE_EN
    chk("t4_sat", bif.score_bcd, 16'h9999);
`else
    chk("t4_wrap", bif.score_bcd, 16'h0000);
`endif
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Random traffic, including restarts, ignored inputs and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 29) == 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
